// File: rtl/keccak_pkg.sv
// Shared Keccak/SHAKE128 constants and the squeeze sequencer state encoding.
package keccak_pkg;

    localparam int unsigned DATA_SIZE  = 64;
    localparam int unsigned RATE_WORDS = 21;
    localparam int unsigned RATE_BITS  = 1344;

    typedef logic [1:0] sqz_state_t;

    localparam sqz_state_t ST_IDLE      = 2'd0;
    localparam sqz_state_t ST_PERM_WAIT = 2'd1;
    localparam sqz_state_t ST_LOAD      = 2'd2;
    localparam sqz_state_t ST_STREAM    = 2'd3;

endpackage

// File: rtl/keccak_squeeze_ctrl.sv
// Squeeze-phase sequencer: requests permutations, loads the PISO and streams words out.
// Optional KECCAK_SQZ_ABORT_EN adds an abort input that returns the FSM to idle.
module keccak_squeeze_ctrl #(
    parameter int unsigned DATA_SIZE  = keccak_pkg::DATA_SIZE,
    parameter int unsigned RATE_WORDS = keccak_pkg::RATE_WORDS,
    parameter int unsigned LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] out_len_words,
`ifdef KECCAK_SQZ_ABORT_EN
    input  logic             abort,
`endif
    output logic             perm_start,
    input  logic             perm_done,
    output logic             piso_load_en,
    output logic             piso_shift_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done
);
    import keccak_pkg::*;

    localparam int unsigned IDX_W = (RATE_WORDS > 1) ? $clog2(RATE_WORDS) : 1;

    // The word count per block must fill the rate exactly.
    if (RATE_WORDS * DATA_SIZE != RATE_BITS) begin : g_cfg_err
        $error("RATE_WORDS * DATA_SIZE must equal RATE_BITS");
    end

    sqz_state_t       state_q, state_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic             perm_first_q, perm_first_d;
    logic             done_q, done_d;
    logic             handshake;
    logic             abort_req;

`ifdef KECCAK_SQZ_ABORT_EN
    assign abort_req = abort & (state_q != ST_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign out_valid     = (state_q == ST_STREAM);
    assign handshake     = out_valid & out_ready;
    assign piso_shift_en = handshake;
    assign piso_load_en  = (state_q == ST_LOAD);
    assign perm_start    = (state_q == ST_PERM_WAIT) & perm_first_q;
    assign out_last      = out_valid & (remaining_q == LEN_W'(1));
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        word_idx_d   = word_idx_q;
        perm_first_d = 1'b0;
        done_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (out_len_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        remaining_d  = out_len_words;
                        word_idx_d   = '0;
                        perm_first_d = 1'b1;
                        state_d      = ST_PERM_WAIT;
                    end
                end
            end
            ST_PERM_WAIT: begin
                if (perm_done) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                word_idx_d = '0;
                state_d    = ST_STREAM;
            end
            ST_STREAM: begin
                if (handshake) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    word_idx_d  = word_idx_q + IDX_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (word_idx_q == IDX_W'(RATE_WORDS - 1)) begin
                        perm_first_d = 1'b1;
                        state_d      = ST_PERM_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort wins over any same-cycle handshake or permutation completion.
        if (abort_req) begin
            state_d      = ST_IDLE;
            perm_first_d = 1'b0;
            done_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            word_idx_q   <= '0;
            perm_first_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            word_idx_q   <= word_idx_d;
            perm_first_q <= perm_first_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_keccak_squeeze_ctrl.sv
// Directed bench for keccak_squeeze_ctrl with a behavioural PISO and round engine.
module tb_keccak_squeeze_ctrl;

    localparam int RW = 21;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] out_len_words;
    logic        perm_start, perm_done;
    logic        piso_load_en, piso_shift_en;
    logic        out_valid, out_ready, out_last, busy, done;
`ifdef KECCAK_SQZ_ABORT_EN
    logic        abort;
`endif
    logic [6:0]  outs;

    assign outs = {perm_start, piso_load_en, piso_shift_en, out_valid, out_last, busy, done};

    keccak_squeeze_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .out_len_words (out_len_words),
`ifdef KECCAK_SQZ_ABORT_EN
        .abort         (abort),
`endif
        .perm_start    (perm_start),
        .perm_done     (perm_done),
        .piso_load_en  (piso_load_en),
        .piso_shift_en (piso_shift_en),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_last      (out_last),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Monitor state, owned by the monitor process; cleared on request.
    int  cyc = 0;
    bit  clr = 1'b0;
    int  n_perm, n_load, n_beat, n_last, n_done, n_busy, n_valid, n_stall;
    int  bad, order_err, drop, last_beat;
    int  first_perm, first_load, first_valid, pd_cyc, first_hs, last_hs, prev_hs, done_cyc;
    int  piso_base, piso_ptr, blk;
    bit  seen_valid, fin;

    // Stimulus knobs.
    int  lat = 0;
    int  mode = 0;
    logic [3:0] pat = 4'b1001;
    int  start_cyc;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (clr) begin
                n_perm = 0; n_load = 0; n_beat = 0; n_last = 0; n_done = 0; n_busy = 0;
                n_valid = 0; n_stall = 0; bad = 0; order_err = 0; drop = 0; last_beat = 0;
                first_perm = -1; first_load = -1; first_valid = -1; pd_cyc = -1;
                first_hs = -1; last_hs = -1; prev_hs = -1; done_cyc = -1;
                piso_base = 0; piso_ptr = 0; blk = 0; seen_valid = 0; fin = 0;
            end else begin
                if (perm_start) begin
                    n_perm++;
                    if (first_perm < 0) first_perm = cyc;
                end
                if (perm_done && pd_cyc < 0) pd_cyc = cyc;
                if (piso_load_en) begin
                    n_load++;
                    piso_base = blk * RW;
                    piso_ptr = 0;
                    blk++;
                    if (first_load < 0) first_load = cyc;
                end
                if (piso_load_en && piso_shift_en) bad++;
                if (piso_shift_en !== (out_valid & out_ready)) bad++;
                if (out_last && !out_valid) bad++;
                if (out_valid) begin
                    n_valid++;
                    seen_valid = 1;
                    if (first_valid < 0) first_valid = cyc;
                end
                if (seen_valid && !fin && !out_valid) drop++;
                if (out_valid && !out_ready) n_stall++;
                if (out_valid && out_ready) begin
                    if (piso_base + piso_ptr != n_beat) order_err++;
                    piso_ptr++;
                    n_beat++;
                    if (first_hs < 0) first_hs = cyc;
                    prev_hs = last_hs;
                    last_hs = cyc;
                    if (out_last) begin
                        n_last++;
                        last_beat = n_beat;
                        fin = 1;
                    end
                end
                if (busy) n_busy++;
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                end
            end
            cyc++;
        end
    end

    // Round engine: answers each perm_start after lat cycles with a one-cycle perm_done.
    initial begin
        perm_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (perm_start) begin
                repeat (lat) begin
                    @(posedge clk);
                    #1;
                end
                perm_done = 1'b1;
                @(posedge clk);
                #1;
                perm_done = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
        end
    end

    task automatic clear();
        clr = 1'b1;
        @(negedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int len, input int lt);
        lat = lt;
        clear();
        start_cyc = cyc;
        start = 1'b1;
        out_len_words = 16'(len);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 3000 && n_done == 0; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_finished"}, int'(n_done != 0), 1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 3000 && n_beat < n; i++) begin
            @(posedge clk);
            #1;
        end
        check("reach_beat", n_beat, n);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        out_len_words = '0;
`ifdef KECCAK_SQZ_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        check("reset_outs", int'(outs), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_outs", int'(outs), 0);

        // len=5, latency 3: basic timing
        kick(5, 3);
        wait_done("len5");
        check("len5_perm", n_perm, 1);
        check("len5_perm_lat", first_perm - start_cyc, 1);
        check("len5_load_lat", first_load - pd_cyc, 1);
        check("len5_valid_lat", first_valid - pd_cyc, 2);
        check("len5_load", n_load, 1);
        check("len5_beats", n_beat, 5);
        check("len5_burst", last_hs - first_hs, 4);
        check("len5_last", last_beat, 5);
        check("len5_nlast", n_last, 1);
        check("len5_done", n_done, 1);
        check("len5_done_lat", done_cyc - last_hs, 1);
        check("len5_order", order_err, 0);
        check("len5_excl", bad, 0);

        // len=21, perm_done in the first PERM_WAIT cycle
        kick(21, 0);
        wait_done("len21");
        check("len21_perm", n_perm, 1);
        check("len21_load", n_load, 1);
        check("len21_beats", n_beat, 21);
        check("len21_last", last_beat, 21);
        check("len21_burst", last_hs - first_hs, 20);
        check("len21_order", order_err, 0);

        // len=22, latency 2: second block
        kick(22, 2);
        wait_done("len22");
        check("len22_perm", n_perm, 2);
        check("len22_load", n_load, 2);
        check("len22_beats", n_beat, 22);
        check("len22_last", last_beat, 22);
        check("len22_gap", last_hs - prev_hs, 2 + 2 + 1);
        check("len22_order", order_err, 0);
        check("len22_excl", bad, 0);

        // Backpressure 1,0,0,1
        mode = 1;
        kick(6, 2);
        wait_done("bp");
        mode = 0;
        check("bp_beats", n_beat, 6);
        check("bp_stalls_seen", int'(n_stall != 0), 1);
        check("bp_valid_held", drop, 0);
        check("bp_order", order_err, 0);
        check("bp_shift_on_hs", bad, 0);
        check("bp_last", last_beat, 6);

        // len=0
        kick(0, 1);
        wait_done("len0");
        check("len0_done_lat", done_cyc - start_cyc, 1);
        check("len0_ndone", n_done, 1);
        check("len0_perm", n_perm, 0);
        check("len0_load", n_load, 0);
        check("len0_valid", n_valid, 0);
        check("len0_busy", n_busy, 0);

        // Reset while streaming word 7
        kick(21, 1);
        wait_beats(7);
        check("rst_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        check("rst_outs", int'(outs), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear();
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_done", n_done, 0);
        check("rst_idle", n_busy, 0);
        kick(3, 1);
        wait_done("after_rst");
        check("after_rst_perm", n_perm, 1);
        check("after_rst_beats", n_beat, 3);
        check("after_rst_last", last_beat, 3);
        check("after_rst_order", order_err, 0);

`ifdef KECCAK_SQZ_ABORT_EN
        kick(21, 1);
        wait_beats(7);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_outs", int'(outs), 0);
        clear();
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", n_done, 0);
        kick(3, 1);
        wait_done("after_abort");
        check("after_abort_beats", n_beat, 3);
        check("after_abort_perm", n_perm, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
